// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared state encoding and address-split constants for the direct-mapped I-cache.
package icache_dm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, DRAIN = 2'd2} state_e;
  localparam int BYTE_OFF_W = 2;
endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: miss detection, line refill over req/ack and drain after a mid-refill flush.
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W = 32,
  localparam int OFF_W = $clog2(WORDS_PER_LINE),
  localparam int IDX_W = $clog2(LINES),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BYTE_OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              hit_i,
  input  logic              flush_i,
  input  logic [TAG_W-1:0]  cpu_tag_i,
  input  logic [IDX_W-1:0]  cpu_idx_i,
  input  logic              mem_ack_i,
  output state_e            state_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [TAG_W-1:0]  miss_tag_o,
  output logic [IDX_W-1:0]  miss_idx_o,
  output logic [OFF_W-1:0]  cnt_o,
  output logic              miss_start_o,
  output logic              word_we_o,
  output logic              line_done_o
);
  state_e             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic               last;

  assign last = cnt_q == OFF_W'(WORDS_PER_LINE - 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    miss_start_o = state_q == IDLE && cpu_req_i && !hit_i && !flush_i;
    word_we_o    = state_q == REFILL && mem_ack_i;
    line_done_o  = word_we_o && last && !flush_i;
    if (miss_start_o) begin
      state_d    = REFILL;
      cnt_d      = '0;
      miss_tag_d = cpu_tag_i;
      miss_idx_d = cpu_idx_i;
    end else if (state_q == REFILL) begin
      // an ack completes the outstanding word, so a flush with it needs no drain
      if (mem_ack_i) begin
        state_d = (last || flush_i) ? IDLE : REFILL;
        cnt_d   = cnt_q + 1'b1;
      end else if (flush_i) begin
        state_d = DRAIN;
      end
    end else if (state_q == DRAIN && mem_ack_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  assign state_o    = state_q;
  assign mem_req_o  = state_q != IDLE;
  assign mem_addr_o = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
  assign miss_tag_o = miss_tag_q;
  assign miss_idx_o = miss_idx_q;
  assign cnt_o      = cnt_q;
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache; combinational hit path, stall during refill.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_instr,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BYTE_OFF_W;

  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] cpu_tag, miss_tag;
  logic [IDX_W-1:0] cpu_idx, miss_idx;
  logic [OFF_W-1:0] cpu_off, cnt;
  logic             hit, miss_start, word_we, line_done, unused_ok;
  state_e           state;

  assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx   = cpu_addr[BYTE_OFF_W+OFF_W +: IDX_W];
  assign cpu_off   = cpu_addr[BYTE_OFF_W +: OFF_W];
  assign unused_ok = ^cpu_addr[BYTE_OFF_W-1:0];
  assign hit       = valid_q[cpu_idx] && tag_q[cpu_idx] == cpu_tag;
  assign cpu_instr = data_q[cpu_idx][cpu_off];
  assign cpu_stall = reset && cpu_req && (state != IDLE || !hit);

  icache_refill_fsm #(
    .LINES(LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clock       (clock),
    .reset       (reset),
    .cpu_req_i   (cpu_req),
    .hit_i       (hit),
    .flush_i     (flush),
    .cpu_tag_i   (cpu_tag),
    .cpu_idx_i   (cpu_idx),
    .mem_ack_i   (mem_ack),
    .state_o     (state),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .miss_tag_o  (miss_tag),
    .miss_idx_o  (miss_idx),
    .cnt_o       (cnt),
    .miss_start_o(miss_start),
    .word_we_o   (word_we),
    .line_done_o (line_done)
  );

  // the refilling line stays invalid until its last word lands; flush overrides everything
  always_comb begin
    valid_d = valid_q;
    if (miss_start) valid_d[cpu_idx] = 1'b0;
    if (line_done) valid_d[miss_idx] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) valid_q <= '0;
    else valid_q <= valid_d;
  end

  always_ff @(posedge clock) begin
    if (word_we) data_q[miss_idx][cnt] <= mem_rdata;
    if (line_done) tag_q[miss_idx] <= miss_tag;
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed table of fetches plus hand-written flush/reset corner sequences.
module tb_icache_dm;
  localparam int K = 2;

  logic        clock = 1'b0;
  logic        reset, cpu_req, flush, mem_req, mem_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_instr, mem_addr, mem_rdata;
  logic        auto_en, force_ack;
  int          wcnt = 0;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    int          stalls;
    logic [31:0] instr;
  } vec_t;
  vec_t tbl[9];

  always #5 clock = ~clock;

  icache_dm dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_instr(cpu_instr),
    .cpu_stall(cpu_stall),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  // backing memory: word at address a is {~a[15:0], a[15:0]}, acked K cycles into each request
  assign mem_rdata = {~mem_addr[15:0], mem_addr[15:0]};
  assign mem_ack   = force_ack || (auto_en && mem_req && wcnt >= K - 1);
  always @(posedge clock) wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic man_ack();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cpu_stall && n < 100) begin
      @(posedge clock);
      #3;
      n++;
    end
    chk(name, {31'd0, cpu_stall}, 32'd0);
  endtask

  task automatic access(input logic [31:0] a, input int exp_stalls, input logic [31:0] exp_instr);
    int stalls = 0;
    int acks = 0;
    tick();
    cpu_req = 1'b1;
    cpu_addr = a;
    #2;
    while (cpu_stall && stalls < 100) begin
      stalls++;
      if (mem_req && mem_ack) begin
        chk($sformatf("addr_%h_w%0d", a, acks), mem_addr, {a[31:4], 4'h0} + 32'(4 * acks));
        acks++;
      end
      @(posedge clock);
      #3;
    end
    chk($sformatf("stalls_%h", a), 32'(stalls), 32'(exp_stalls));
    chk($sformatf("acks_%h", a), 32'(acks), exp_stalls > 0 ? 32'd4 : 32'd0);
    chk($sformatf("instr_%h", a), cpu_instr, exp_instr);
    chk($sformatf("req_after_%h", a), {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h000, 9, 32'hFFFF_0000};
    tbl[1] = '{32'h008, 0, 32'hFFF7_0008};
    tbl[2] = '{32'h00C, 0, 32'hFFF3_000C};
    tbl[3] = '{32'h100, 9, 32'hFEFF_0100};
    tbl[4] = '{32'h104, 0, 32'hFEFB_0104};
    tbl[5] = '{32'h000, 9, 32'hFFFF_0000};
    tbl[6] = '{32'h0F4, 9, 32'hFF0B_00F4};
    tbl[7] = '{32'h0F0, 0, 32'hFF0F_00F0};
    tbl[8] = '{32'h004, 0, 32'hFFFB_0004};

    reset = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0; flush = 1'b0;
    auto_en = 1'b1; force_ack = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    tick();
    reset = 1'b1;
    cpu_req = 1'b0;

    foreach (tbl[i]) access(tbl[i].addr, tbl[i].stalls, tbl[i].instr);

    tick();
    cpu_req = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    access(32'h004, 9, 32'hFFFB_0004);

    // flush while word 1 is outstanding: drain, then refill from word 0
    tick();
    auto_en = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = 32'h020;
    #2;
    chk("fm_miss_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    chk("fm_w0_addr", mem_addr, 32'h020);
    man_ack();
    tick();
    chk("fm_w1_addr", mem_addr, 32'h024);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fm_drain_req", {31'd0, mem_req}, 32'd1);
    chk("fm_drain_addr", mem_addr, 32'h024);
    chk("fm_drain_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    chk("fm_drain_hold", {31'd0, mem_req}, 32'd1);
    man_ack();
    #2;
    chk("fm_idle_req", {31'd0, mem_req}, 32'd0);
    chk("fm_idle_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    chk("fm_rerefill_addr", mem_addr, 32'h020);
    auto_en = 1'b1;
    wait_idle("fm_done");
    chk("fm_instr", cpu_instr, 32'hFFDF_0020);

    // flush coincides with the ack of the last word: line must stay invalid
    tick();
    auto_en = 1'b0;
    cpu_addr = 32'h060;
    tick();
    repeat (3) man_ack();
    chk("fl_w3_addr", mem_addr, 32'h06C);
    flush = 1'b1;
    force_ack = 1'b1;
    tick();
    flush = 1'b0;
    force_ack = 1'b0;
    #2;
    chk("fl_req", {31'd0, mem_req}, 32'd0);
    chk("fl_invalid", {31'd0, cpu_stall}, 32'd1);
    auto_en = 1'b1;
    wait_idle("fl_done");
    chk("fl_instr", cpu_instr, 32'hFF9F_0060);

    // reset during word 2 of a refill; a late ack must be ignored
    tick();
    cpu_addr = 32'h040;
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 32'h048) && n < 100) begin
        tick();
        n++;
      end
    end
    chk("rm_reach_w2", mem_addr, 32'h048);
    reset = 1'b0;
    auto_en = 1'b0;
    tick();
    chk("rm_req", {31'd0, mem_req}, 32'd0);
    chk("rm_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rm_addr", mem_addr, 32'd0);
    force_ack = 1'b1;
    tick();
    reset = 1'b1;
    force_ack = 1'b0;
    #2;
    chk("rm_after_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rm_after_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("rm_restart_addr", mem_addr, 32'h040);
    auto_en = 1'b1;
    wait_idle("rm_done");
    chk("rm_instr", cpu_instr, 32'hFFBF_0040);
    access(32'h000, 9, 32'hFFFF_0000);
    access(32'h0F8, 9, 32'hFF07_00F8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
